// File: rtl/hamming_tx_scheduler.sv
// Two-requester round-robin front end for a shared Hamming (21,16) encoder and serial line.
// Optional HAMMING_TX_SECDED_EN appends an overall even-parity bit, making 22-bit frames.
module hamming_tx_scheduler #(
   parameter int CLKS_PER_BIT = 4,
   parameter int GAP_CLKS     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   output logic        req0_ack,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   output logic        req1_ack,
   output logic [15:0] enc_indata,
   output logic        enc_readready,
   input  logic [20:0] enc_outdata,
   input  logic        enc_writeready,
   output logic        tx_bit,
   output logic        tx_start,
   output logic        tx_busy,
   output logic        last_grant,
   output logic [1:0]  state_dbg
);

`ifdef HAMMING_TX_SECDED_EN
   localparam int FRAME_BITS = 22;
`else
   localparam int FRAME_BITS = 21;
`endif
   localparam int LAST_BIT = FRAME_BITS - 1;

   // Handshakes: reqN_valid/reqN_data are held by the requester until the
   // one-cycle reqN_ack; enc_readready is held until enc_writeready is seen.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      SHIFT  = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             enc_indata_q, enc_indata_d;
   logic                    ack0_q, ack0_d;
   logic                    ack1_q, ack1_d;
   logic                    last_grant_q, last_grant_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic [15:0]             per_cnt_q, per_cnt_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic [3:0]              to_cnt_q, to_cnt_d;
   logic [FRAME_BITS-1:0]   capture_w;
   logic                    grant1_w;

`ifdef HAMMING_TX_SECDED_EN
   assign capture_w = {^enc_outdata, enc_outdata};
`else
   assign capture_w = enc_outdata;
`endif

   // On a tie the requester that was not served last wins.
   assign grant1_w = req1_valid && (!req0_valid || !last_grant_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         enc_indata_q <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         last_grant_q <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         per_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         enc_indata_q <= enc_indata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         last_grant_q <= last_grant_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         per_cnt_q    <= per_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      enc_indata_d = enc_indata_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      last_grant_d = last_grant_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      per_cnt_d    = per_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      to_cnt_d     = to_cnt_q;
      unique case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            per_cnt_d = '0;
            gap_cnt_d = '0;
            to_cnt_d  = '0;
            if (req0_valid || req1_valid) begin
               state_d      = ENCODE;
               ack0_d       = !grant1_w;
               ack1_d       = grant1_w;
               enc_indata_d = grant1_w ? req1_data : req0_data;
               last_grant_d = grant1_w;
            end
         end
         ENCODE: begin
            if (enc_writeready) begin
               shift_d   = capture_w;
               state_d   = SHIFT;
               bit_cnt_d = '0;
               per_cnt_d = '0;
            end else if (to_cnt_q == 4'd15) begin
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 4'd1;
            end
         end
         SHIFT: begin
            if (per_cnt_q == 16'(CLKS_PER_BIT - 1)) begin
               per_cnt_d = '0;
               if (bit_cnt_q == 5'(LAST_BIT)) begin
                  gap_cnt_d = '0;
                  state_d   = (GAP_CLKS == 0) ? IDLE : GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  shift_d   = shift_q >> 1;
               end
            end else begin
               per_cnt_d = per_cnt_q + 16'd1;
            end
         end
         GAP: begin
            if (gap_cnt_q == 8'(GAP_CLKS - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req0_ack      = ack0_q;
   assign req1_ack      = ack1_q;
   assign enc_indata    = enc_indata_q;
   assign enc_readready = (state_q == ENCODE);
   assign tx_bit        = (state_q == SHIFT) ? shift_q[0] : 1'b1;
   assign tx_start      = (state_q == SHIFT) && (bit_cnt_q == 5'd0);
   assign tx_busy       = (state_q != IDLE);
   assign last_grant    = last_grant_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed bench for hamming_tx_scheduler with a combinational encoder model.
// Frame width follows HAMMING_TX_SECDED_EN the same way the design does.
module tb_hamming_tx_scheduler;

   localparam int CPB = 4;
   localparam int GAP = 8;
`ifdef HAMMING_TX_SECDED_EN
   localparam int FB = 22;
`else
   localparam int FB = 21;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic        req0_ack, req1_ack;
   logic [15:0] enc_indata;
   logic        enc_readready;
   logic [20:0] enc_outdata;
   logic        enc_writeready;
   logic        tx_bit, tx_start, tx_busy, last_grant;
   logic [1:0]  state_dbg;
   logic        wr_en = 1'b1;

   int checks = 0;
   int errors = 0;
   int ack0_cnt = 0;
   int ack1_cnt = 0;

   always #5 clk = ~clk;

   hamming_tx_scheduler #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ack(req0_ack),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ack(req1_ack),
      .enc_indata(enc_indata), .enc_readready(enc_readready),
      .enc_outdata(enc_outdata), .enc_writeready(enc_writeready),
      .tx_bit(tx_bit), .tx_start(tx_start), .tx_busy(tx_busy),
      .last_grant(last_grant), .state_dbg(state_dbg)
   );

   function automatic logic [20:0] enc_model(input logic [15:0] d);
      case (d)
         16'h0001: return 21'h000007;
         16'hFFFF: return 21'h1FFFFF;
         default:  return {d, d[4:0] ^ 5'h15};
      endcase
   endfunction

   function automatic logic [21:0] frame_of(input logic [20:0] c);
`ifdef HAMMING_TX_SECDED_EN
      return {^c, c};
`else
      return {1'b0, c};
`endif
   endfunction

   assign enc_outdata    = enc_model(enc_indata);
   assign enc_writeready = enc_readready & wr_en;

   always @(posedge clk) begin
      if (req0_ack) ack0_cnt <= ack0_cnt + 1;
      if (req1_ack) ack1_cnt <= ack1_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tx_bit", tx_bit, 1);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_ack0", req0_ack, 0);
      check("rst_ack1", req1_ack, 0);
      check("rst_readready", enc_readready, 0);
      check("rst_indata", enc_indata, 0);
      check("rst_last_grant", last_grant, 1);
      reset = 1'b0;
   endtask

   // Returns 0/1 for the acked requester, or 2 if no ack within the budget.
   task automatic wait_ack(output int who);
      int i = 0;
      while (!(req0_ack || req1_ack) && i < 20) begin
         @(negedge clk);
         i++;
      end
      check("ack_seen", (req0_ack || req1_ack), 1);
      who = req1_ack ? 1 : (req0_ack ? 0 : 2);
   endtask

   task automatic run_frame(input logic [15:0] data, input string tag);
      logic [21:0] fr;
      int i = 0;
      fr = frame_of(enc_model(data));
      while (tx_start !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_start_seen"}, tx_start, 1);
      for (int b = 0; b < FB; b++) begin
         for (int c = 0; c < CPB; c++) begin
            check($sformatf("%s_bit%0d", tag, b), tx_bit, fr[b]);
            check($sformatf("%s_start%0d", tag, b), tx_start, (b == 0));
            @(negedge clk);
         end
      end
      for (int g = 0; g < GAP; g++) begin
         check({tag, "_gap_bit"}, tx_bit, 1);
         check({tag, "_gap_busy"}, tx_busy, 1);
         @(negedge clk);
      end
      check({tag, "_idle_busy"}, tx_busy, 0);
      check({tag, "_idle_bit"}, tx_bit, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      int a0, a1;
      logic [21:0] fr;

      // Single request from requester 0
      do_reset();
      a0 = ack0_cnt;
      req0_valid = 1'b1;
      req0_data  = 16'h0001;
      @(negedge clk);
      check("t1_ack0", req0_ack, 1);
      check("t1_ack1", req1_ack, 0);
      check("t1_readready", enc_readready, 1);
      check("t1_indata", enc_indata, 16'h0001);
      check("t1_busy", tx_busy, 1);
      check("t1_last_grant", last_grant, 0);
      check("t1_no_start_yet", tx_start, 0);
      req0_valid = 1'b0;
      @(negedge clk);
      check("t1_ack0_drop", req0_ack, 0);
      check("t1_readready_drop", enc_readready, 0);
      check("t1_first_bit_latency", tx_start, 1);
      run_frame(16'h0001, "t1");
      check("t1_ack0_pulses", ack0_cnt - a0, 1);

      // Both valid continuously: strict alternation from reset
      do_reset();
      req0_valid = 1'b1; req0_data = 16'h0000;
      req1_valid = 1'b1; req1_data = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         wait_ack(who);
         check($sformatf("t2_grant%0d", k), who, k % 2);
         check($sformatf("t2_last_grant%0d", k), last_grant, k % 2);
         check($sformatf("t2_start_after_ack%0d", k), tx_start, 0);
         run_frame((k % 2) ? 16'hFFFF : 16'h0000, $sformatf("t2f%0d", k));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Requester 1 alone
      a0 = ack0_cnt;
      a1 = ack1_cnt;
      req1_valid = 1'b1; req1_data = 16'hFFFF;
      wait_ack(who);
      check("t3_grant", who, 1);
      req1_valid = 1'b0;
      run_frame(16'hFFFF, "t3");
      check("t3_no_ack0", ack0_cnt - a0, 0);
      check("t3_one_ack1", ack1_cnt - a1, 1);

      // Encoder never answers: timeout after 16 cycles
      wr_en = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h1234;
      wait_ack(who);
      check("t4_grant", who, 0);
      req0_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("t4_readready%0d", k), enc_readready, 1);
         check($sformatf("t4_no_start%0d", k), tx_start, 0);
         check($sformatf("t4_tx_bit%0d", k), tx_bit, 1);
         check($sformatf("t4_busy%0d", k), tx_busy, 1);
         @(negedge clk);
      end
      check("t4_timeout_readready", enc_readready, 0);
      check("t4_timeout_busy", tx_busy, 0);
      check("t4_timeout_bit", tx_bit, 1);
      wr_en = 1'b1;
      req1_valid = 1'b1; req1_data = 16'hABCD;
      wait_ack(who);
      check("t4_next_grant", who, 1);
      req1_valid = 1'b0;
      run_frame(16'hABCD, "t4");

      // Reset during bit 10 aborts the frame; the pending word is served after
      req0_valid = 1'b1; req0_data = 16'h0001;
      wait_ack(who);
      check("t5_grant", who, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 16'h5555;
      a1 = ack1_cnt;
      @(negedge clk);
      check("t5_start", tx_start, 1);
      repeat (10 * CPB) @(negedge clk);
      fr = frame_of(enc_model(16'h0001));
      check("t5_bit10_before_reset", tx_bit, fr[10]);
      check("t5_busy_before_reset", tx_busy, 1);
      check("t5_pending_not_acked", ack1_cnt - a1, 0);
      #2 reset = 1'b1;
      #1;
      check("t5_async_tx_bit", tx_bit, 1);
      check("t5_async_busy", tx_busy, 0);
      check("t5_async_start", tx_start, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_ack(who);
      check("t5_reack_grant", who, 1);
      check("t5_reack_last_grant", last_grant, 1);
      req1_valid = 1'b0;
      run_frame(16'h5555, "t5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hamming_tx_scheduler.md
Name: hamming_tx_scheduler

Overview:
- Two-requester round-robin scheduler that shares one Hamming (21,16) encoder and one serial transmit line.
- Accepts 16-bit words from requester 0 (sensor path) and requester 1 (control path), and drives the encoder through its readready/writeready handshake.
- Captures each 21-bit codeword, then shifts it out LSB-first at a parameterised bit period with an inter-frame gap.
- Sits between the FPGA data sources and the channel transmitter.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_bit (legal range 1 to 65535).
- GAP_CLKS, 8, idle cycles between frames with tx_bit=1 and tx_busy=1 (legal range 0 to 255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word pending.
- req0_data  in  16  requester 0 word.
- req0_ack  out  1  one-cycle pulse: req0_data captured.
- req1_valid  in  1  requester 1 has a word pending.
- req1_data  in  16  requester 1 word.
- req1_ack  out  1  one-cycle pulse: req1_data captured.
- enc_indata  out  16  word presented to the encoder.
- enc_readready  out  1  request to the encoder.
- enc_outdata  in  21  codeword from the encoder.
- enc_writeready  in  1  encoder output valid.
- tx_bit  out  1  serial line, idles high.
- tx_start  out  1  high for the first bit period of each frame.
- tx_busy  out  1  high from grant until the gap ends.
- last_grant  out  1  requester served most recently.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_bit=1, tx_start=0, tx_busy=0, req0_ack=0, req1_ack=0, enc_readready=0, enc_indata=0, last_grant=1 (so requester 0 wins first), all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no ack is reissued.
- IDLE:
  - If any reqN_valid is sampled high, grant one requester at the edge and move to ENCODE.
  - Assert that requester's reqN_ack for exactly the next cycle.
  - Latch its data into enc_indata.
  - Set last_grant to the granted index and tx_busy=1.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - Requesters hold valid/data until ack; valid sampled during ack is treated as a new word.
- ENCODE:
  - enc_readready=1. On the first cycle enc_writeready=1, capture enc_outdata into the 21-bit shift register, drop enc_readready, and go to SHIFT.
  - If enc_writeready stays low for 16 cycles, drop the word and return to IDLE with tx_busy=0 (timeout).
- SHIFT:
  - tx_bit = shift_reg[0]; the bit counter runs 0..20 and the period counter runs 0..CLKS_PER_BIT-1.
  - At period wrap, shift right and increment the bit counter.
  - tx_start=1 only while the bit counter=0.
  - After bit 20's period, go to GAP, or to IDLE if GAP_CLKS=0.
- GAP: tx_bit=1; count GAP_CLKS cycles, then go to IDLE and clear tx_busy in the same edge.
- Frame length: 21*CLKS_PER_BIT cycles. Grant-to-first-bit latency: 2 cycles with an immediate enc_writeready.
- Requests arriving outside IDLE wait; they are never acked until the scheduler returns to IDLE.
- Back-to-back frames with both requesters valid continuously alternate 0,1,0,1.
- Counters never wrap past their terminal value; they reset on state entry.

Optional Feature:
- Macro: HAMMING_TX_SECDED_EN.
- Defined: at capture, append an overall even-parity bit (XOR of all 21 codeword bits) as bit 21. The frame is 22 bits; the bit counter runs 0..21.
- Undefined: 21-bit frames exactly as above; no parity logic is synthesised.

Test Plan:
- Reset, then req0_valid=1, req0_data=16'h0001, encoder model answers same cycle -> req0_ack pulse 1 cycle; tx_start high 4 cycles; tx_bit sequence LSB-first = 1,1,1 then eighteen 0s (codeword 21'h000007); tx_busy low 8 cycles after last bit.
- req0 and req1 valid together from reset, data 16'h0000 and 16'hFFFF -> grants in order 0,1,0,1; last_grant toggles; each ack precedes its frame.
- req1 only, data 16'hFFFF -> frame equals encoder's 21'h1FFFFF bit-serially, LSB-first; req0_ack never asserts.
- enc_writeready held low -> after 16 cycles, return to IDLE, tx_bit stays 1, no tx_start; next request is served normally.
- Reset asserted at bit 10 of a frame -> tx_bit=1, tx_busy=0 the same cycle (async); pending valid re-acked after release.
- HAMMING_TX_SECDED_EN defined, data 16'h0001 -> 22-bit frame, bit 21 = 1 (odd weight 3 makes parity 1).
